// File: rtl/csa_resolve_pipe.sv
// Carry-save to binary resolver (result = sum + 2*carry), carry chain split over STAGES registered chunks.
// Latency STAGES cycles, one result per cycle; bubbles collapse and in_ready drops only when every stage is full and stalled.
module csa_resolve_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] out_result
);
   localparam int N     = WIDTH + 2;
   localparam int CHUNK = (N + STAGES - 1) / STAGES;

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] rdy;
   logic [N-1:0]      a_q [STAGES];
   logic [N-1:0]      b_q [STAGES];
   logic              c_q [STAGES];

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         localparam int LO = k * CHUNK;
         localparam int HI = ((k + 1) * CHUNK > N) ? N : (k + 1) * CHUNK;

         logic [N-1:0] a_in;
         logic [N-1:0] b_in;
         logic [N-1:0] a_nxt;
         logic [N-1:0] b_nxt;
         logic         c_in;
         logic         c_nxt;
         logic         v_in;
         logic         v_r;
         logic [N-1:0] a_r;
         logic [N-1:0] b_r;
         logic         c_r;

         if (k == 0) begin : g_head
            assign a_in = {2'b00, in_sum};
            assign b_in = {1'b0, in_carry, 1'b0};
            assign c_in = 1'b0;
            assign v_in = in_valid;
         end else begin : g_link
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = vld[k-1];
         end

         // Only blocked when this stage and every stage after it hold data and the sink stalls.
         assign rdy[k] = out_ready | ~(&vld[STAGES-1:k]);

         if (LO < N) begin : g_add
            logic [HI-LO:0] tot;

            assign tot = {1'b0, a_in[HI-1:LO]} + {1'b0, b_in[HI-1:LO]}
                       + {{(HI-LO){1'b0}}, c_in};

            always_comb begin
               a_nxt          = a_in;
               b_nxt          = b_in;
               a_nxt[HI-1:LO] = tot[HI-LO-1:0];
               b_nxt[HI-1:LO] = '0;
            end

            assign c_nxt = tot[HI-LO];
         end else begin : g_pass
            logic unused_cin;

            assign unused_cin = c_in;
            assign a_nxt      = a_in;
            assign b_nxt      = b_in;
            assign c_nxt      = 1'b0;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_r <= 1'b0;
               a_r <= '0;
               b_r <= '0;
               c_r <= 1'b0;
            end else if (rdy[k]) begin
               v_r <= v_in;
               if (v_in) begin
                  a_r <= a_nxt;
                  b_r <= b_nxt;
                  c_r <= c_nxt;
               end
            end
         end

         assign vld[k] = v_r;
         assign a_q[k] = a_r;
         assign b_q[k] = b_r;
         assign c_q[k] = c_r;
      end
   endgenerate

   // The last stage's B bits are all resolved and its carry-out is zero by construction.
   logic unused_tail;
   assign unused_tail = ^{b_q[STAGES-1], c_q[STAGES-1]};

   assign in_ready   = rdy[0];
   assign out_valid  = vld[STAGES-1];
   assign out_result = a_q[STAGES-1];

   assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_result)));

endmodule

// File: doc/csa_resolve_pipe.md
Name: csa_resolve_pipe

Overview:
Pipelined carry-propagate converter from carry-save form (sum, carry) to a single binary result. It sits at the output of the 3:2 and 4:2 compressor trees (multipliers, multi-operand accumulators) and resolves the redundant pair as result = sum + (carry << 1). The carry chain is split into STAGES register-separated chunks to meet timing on wide datapaths. A valid/ready handshake at each end provides full throughput and backpressure.

Parameters:
WIDTH, 32, bit width of each input vector (sum and carry); result is WIDTH+2 bits; legal range WIDTH >= 1.
STAGES, 2, number of pipeline stages, which is also the latency in cycles; legal range 1 <= STAGES <= WIDTH+2.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input pair valid.
in_ready  output  1  block can accept the input pair this cycle.
in_sum  input  WIDTH  sum vector, weight 1.
in_carry  input  WIDTH  carry vector, weight 2 (bit i has weight 2^(i+1)).
out_valid  output  1  out_result holds a resolved value.
out_ready  input  1  downstream accepts out_result this cycle.
out_result  output  WIDTH+2  in_sum + 2*in_carry, zero-extended, exact (no overflow possible).

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid bit and every data/carry register. out_valid=0, out_result=0, in_ready=1 while in reset and in the first cycle after it.
- Operand alignment at entry: A = {2'b00, in_sum}, B = {1'b0, in_carry, 1'b0}, N = WIDTH+2 bits.
- Chunking: CHUNK = ceil(N/STAGES). Stage k (0-based) adds bits [k*CHUNK, min((k+1)*CHUNK, N)-1] of A and B plus the carry-in from stage k-1 (0 for stage 0). It registers the resolved low bits, the still-unresolved upper A/B bits, and the carry-out.
- A stage whose range is empty (k*CHUNK >= N) is a pass-through register with valid. Its carry-out is 0.
- The final carry-out out of bit N-1 is always 0 by construction. It is discarded.
- Stage handshake: ready_STAGES = out_ready. ready_k = !valid_k || ready_(k+1). Stage k loads when ready_k is 1. valid_k takes valid_(k-1) (in_valid for k=0). Data registers load only when the incoming valid is 1.
- in_ready = ready_0. This is a combinational path from out_ready, which is accepted by design. out_valid = valid_(STAGES-1). out_result = last-stage result register.
- Latency: a pair accepted in cycle t (in_valid & in_ready) appears with out_valid=1 in cycle t+STAGES when there are no stalls.
- Throughput: one result per cycle while out_ready=1. No bubbles are inserted.
- Backpressure: while out_valid=1 and out_ready=0, out_result and out_valid hold stable. Upstream bubbles are squeezed out, so stages behind a bubble still advance. Once all STAGES registers are valid, in_ready=0.
- Simultaneous accept/emit on a full pipe (out_ready=1, in_valid=1): both transfers occur in the same cycle and the pipe stays full.
- in_valid=0: no state change except advancement of held entries. Data registers of invalid stages are don't-care but never reach out_result with out_valid=1.
- Reset mid-operation: all in-flight pairs are dropped. No output appears for them after rst_n rises.
- Ordering: results leave strictly in acceptance order. No reordering and no drops while rst_n=1.

Test Plan:
- WIDTH=8, STAGES=3, single pair in_sum=0xFF, in_carry=0xFF, out_ready=1 -> out_valid high exactly 3 cycles after accept, out_result=0x2FD. out_valid low before and after.
- Full carry ripple across every chunk boundary: WIDTH=8, STAGES=3, in_sum=0xFF, in_carry=0x00 then in_sum=0xFE, in_carry=0x01 -> results 0x0FF then 0x100, on consecutive cycles.
- Back-to-back stream of 16 pairs (in_sum=i, in_carry=3*i) with out_ready=1 -> 16 consecutive out_valid cycles, result=7*i, in order, in_ready constantly 1.
- Backpressure: hold out_ready=0 and offer 5 pairs -> exactly 3 accepted, then in_ready=0. out_result is stable at the first result. After out_ready=1 the remaining pairs drain in order with no loss or duplication.
- Reset mid-stream: assert rst_n low with 2 pairs in flight -> out_valid=0 and out_result=0 immediately. No stale result after release. The next accepted pair returns its correct result.
- Randomised in_valid/out_ready for 10k pairs at WIDTH=32 with STAGES=1, 2, 5 and 34 -> every result equals the scoreboard value in_sum + 2*in_carry, in order.
